ibex_dummy_instr_tracker: RTL and testbench

Consumer-side counterpart to the IF-stage dummy instruction inserter. It records every dummy instruction accepted into ID, decodes the dummy encoding, and checks that what ID completes matches what IF issued. It flags illegal or tampered dummy encodings and tracking inconsistencies as a security alert, and counts retired dummy instructions for a performance/diagnostic counter. It sits alongside the ID stage, fed by IF (insert side) and ID (completion side).

---
 rtl/ibex_dummy_instr_tracker_pkg.sv | 24 ++
 rtl/ibex_dummy_instr_tracker_if.sv | 26 ++
 rtl/ibex_dummy_instr_decode.sv | 17 +
 rtl/ibex_dummy_instr_tracker.sv | 65 ++++++
 tb/tb_ibex_dummy_instr_tracker.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ibex_dummy_instr_tracker_pkg.sv
// ibex_dummy_instr_tracker_pkg: dummy instruction types, encoding constants and encoder shared with the IF inserter
package ibex_dummy_instr_tracker_pkg;
  typedef enum logic [1:0] {
    DummyAdd  = 2'd0,
    DummyMul  = 2'd1,
    DummyMulh = 2'd2,
    DummyAnd  = 2'd3
  } dummy_instr_e;
  localparam logic [6:0] DummyOpcode    = 7'h33;
  localparam logic [6:0] DummyFunct7Add = 7'h00;
  localparam logic [6:0] DummyFunct7Mul = 7'h01;
  localparam logic [2:0] DummyFunct3Add  = 3'b000;
  localparam logic [2:0] DummyFunct3Mul  = 3'b000;
  localparam logic [2:0] DummyFunct3Mulh = 3'b001;
  localparam logic [2:0] DummyFunct3And  = 3'b111;
  function automatic logic [31:0] dummy_encode(dummy_instr_e t, logic [4:0] rs1, logic [4:0] rs2);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = (t == DummyMul || t == DummyMulh) ? DummyFunct7Mul : DummyFunct7Add;
    f3 = t == DummyMulh ? DummyFunct3Mulh : t == DummyAnd ? DummyFunct3And :
         t == DummyMul  ? DummyFunct3Mul  : DummyFunct3Add;
    return {f7, rs2, rs1, f3, 5'h00, DummyOpcode};
  endfunction
endpackage

// File: rtl/ibex_dummy_instr_tracker_if.sv
// ibex_dummy_instr_tracker_if: IF insert / ID completion side signals of the dummy tracker
interface ibex_dummy_instr_tracker_if
  import ibex_dummy_instr_tracker_pkg::*;
#(parameter int unsigned CntWidth = 32);
  logic                insert_accept_i;
  logic [31:0]         insert_data_i;
  logic                id_done_i;
  logic                id_is_dummy_i;
  logic [31:0]         id_instr_i;
  logic                flush_i;
  logic                cnt_clr_i;
  dummy_instr_e        dummy_type_o;
  logic                dummy_legal_o;
  logic [CntWidth-1:0] retired_cnt_o;
  logic                inflight_empty_o;
  logic                alert_o;
  logic [3:0]          err_o;
  modport master (
    output insert_accept_i, insert_data_i, id_done_i, id_is_dummy_i, id_instr_i, flush_i, cnt_clr_i,
    input  dummy_type_o, dummy_legal_o, retired_cnt_o, inflight_empty_o, alert_o, err_o
  );
  modport slave (
    input  insert_accept_i, insert_data_i, id_done_i, id_is_dummy_i, id_instr_i, flush_i, cnt_clr_i,
    output dummy_type_o, dummy_legal_o, retired_cnt_o, inflight_empty_o, alert_o, err_o
  );
endinterface

// File: rtl/ibex_dummy_instr_decode.sv
// ibex_dummy_instr_decode: combinational legality and type decode of a dummy instruction word
module ibex_dummy_instr_decode
  import ibex_dummy_instr_tracker_pkg::*;
(
  input  logic [31:0]  instr_i,
  output logic         legal_o,
  output dummy_instr_e type_o
);
  logic is_add, is_mul, is_mulh, is_and;
  // rs1/rs2 are free, so re-encode each type with the word's own source registers
  assign is_add  = instr_i == dummy_encode(DummyAdd,  instr_i[19:15], instr_i[24:20]);
  assign is_mul  = instr_i == dummy_encode(DummyMul,  instr_i[19:15], instr_i[24:20]);
  assign is_mulh = instr_i == dummy_encode(DummyMulh, instr_i[19:15], instr_i[24:20]);
  assign is_and  = instr_i == dummy_encode(DummyAnd,  instr_i[19:15], instr_i[24:20]);
  assign legal_o = is_add | is_mul | is_mulh | is_and;
  assign type_o  = is_mul ? DummyMul : is_mulh ? DummyMulh : is_and ? DummyAnd : DummyAdd;
endmodule

// File: rtl/ibex_dummy_instr_tracker.sv
// ibex_dummy_instr_tracker: tracks dummy instructions from IF to ID completion, flags tampering, counts retirements
module ibex_dummy_instr_tracker
  import ibex_dummy_instr_tracker_pkg::*;
#(
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned CntWidth  = 32
) (
  input logic clk_i,
  input logic rst_ni,
  ibex_dummy_instr_tracker_if.slave bus
);
  localparam int unsigned PtrW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam int unsigned OccW = $clog2(FifoDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);
  logic [31:0]         mem_q [FifoDepth];
  logic [PtrW-1:0]     rd_q, wr_q;
  logic [OccW-1:0]     occ_q;
  logic [CntWidth-1:0] ret_q;
  logic [3:0]          err_q, err_ev;
  logic                alert_q, legal, empty, full, push_req, pop_req, pop_ok, push_ok, retire;
  ibex_dummy_instr_decode u_dec (
    .instr_i(bus.id_instr_i),
    .legal_o(legal),
    .type_o (bus.dummy_type_o)
  );
  assign empty    = occ_q == '0;
  assign full     = occ_q == OccW'(FifoDepth);
  assign push_req = bus.insert_accept_i & ~bus.flush_i;
  assign pop_req  = bus.id_done_i & bus.id_is_dummy_i & ~bus.flush_i;
  assign pop_ok   = pop_req & ~empty;
  // a same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign push_ok  = push_req & (~full | pop_ok);
  assign err_ev   = {pop_ok & (mem_q[rd_q] != bus.id_instr_i), pop_ok & ~legal,
                     push_req & full & ~pop_ok, pop_req & empty};
  assign retire   = pop_ok & ~|err_ev[3:2];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
      ret_q   <= '0;
      err_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        occ_q <= '0;
      end else begin
        if (push_ok) wr_q <= wr_q == LastPtr ? '0 : wr_q + 1'b1;
        if (pop_ok) rd_q <= rd_q == LastPtr ? '0 : rd_q + 1'b1;
        occ_q <= occ_q + OccW'(push_ok) - OccW'(pop_ok);
      end
      ret_q   <= bus.cnt_clr_i ? '0 : ret_q + CntWidth'(retire & ~&ret_q);
      err_q   <= err_q | err_ev;
      alert_q <= |err_ev;
    end
  end
  always_ff @(posedge clk_i) if (push_ok) mem_q[wr_q] <= bus.insert_data_i;
  assign bus.dummy_legal_o    = legal;
  assign bus.retired_cnt_o    = ret_q;
  assign bus.inflight_empty_o = empty;
  assign bus.alert_o          = alert_q;
  assign bus.err_o            = err_q;
endmodule

// File: tb/tb_ibex_dummy_instr_tracker.sv
// tb_ibex_dummy_instr_tracker: directed and random checks of the dummy tracker against a queue-based model
module tb_ibex_dummy_instr_tracker;
  localparam int Depth = 2;
  localparam int CntMax = 15;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  int m_cnt = 0;
  logic [3:0] m_err = '0;
  bit m_alert = 0;
  ibex_dummy_instr_tracker_if #(.CntWidth(4)) bus ();
  ibex_dummy_instr_tracker #(.FifoDepth(Depth), .CntWidth(4)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] key(logic [31:0] w);
    return w & 32'hFE00_7FFF;
  endfunction
  function automatic bit m_legal(logic [31:0] w);
    logic [31:0] k;
    k = key(w);
    return k == 32'h0000_0033 || k == 32'h0200_0033 || k == 32'h0200_1033 || k == 32'h0000_7033;
  endfunction
  function automatic logic [1:0] m_type(logic [31:0] w);
    logic [31:0] k;
    k = key(w);
    return k == 32'h0200_0033 ? 2'd1 : k == 32'h0200_1033 ? 2'd2 : k == 32'h0000_7033 ? 2'd3 : 2'd0;
  endfunction
  function automatic logic [31:0] rand_dummy();
    logic [1:0] t;
    logic [6:0] f7;
    logic [2:0] f3;
    t  = 2'($urandom_range(0, 3));
    f7 = (t == 2'd1 || t == 2'd2) ? 7'h01 : 7'h00;
    f3 = t == 2'd2 ? 3'b001 : t == 2'd3 ? 3'b111 : 3'b000;
    return {f7, 5'($urandom), 5'($urandom), f3, 5'h00, 7'h33};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_regs(string tag);
    chk({tag, ".retired"}, 32'(bus.retired_cnt_o), 32'(m_cnt));
    chk({tag, ".empty"}, 32'(bus.inflight_empty_o), 32'(q.size() == 0));
    chk({tag, ".alert"}, 32'(bus.alert_o), 32'(m_alert));
    chk({tag, ".err"}, 32'(bus.err_o), 32'(m_err));
  endtask
  task automatic cyc(string tag, bit ins, logic [31:0] d, bit dn, bit tg, logic [31:0] w, bit fl = 0, bit clr = 0);
    logic [3:0] ev;
    logic [31:0] h;
    bit ret;
    bus.insert_accept_i = ins;
    bus.insert_data_i   = d;
    bus.id_done_i       = dn;
    bus.id_is_dummy_i   = tg;
    bus.id_instr_i      = w;
    bus.flush_i         = fl;
    bus.cnt_clr_i       = clr;
    #1;
    chk({tag, ".legal"}, 32'(bus.dummy_legal_o), 32'(m_legal(w)));
    chk({tag, ".type"}, 32'(bus.dummy_type_o), 32'(m_type(w)));
    ev = '0;
    ret = 0;
    if (fl) q.delete();
    else begin
      if (dn && tg) begin
        if (q.size() == 0) ev[0] = 1;
        else begin
          h = q.pop_front();
          ev[3] = h != w;
          ev[2] = !m_legal(w);
          ret = ev[3:2] == 0;
        end
      end
      if (ins) begin
        if (q.size() < Depth) q.push_back(d);
        else ev[1] = 1;
      end
    end
    if (clr) m_cnt = 0;
    else if (ret && m_cnt < CntMax) m_cnt++;
    m_err |= ev;
    m_alert = |ev;
    @(posedge clk);
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask
  task automatic idle();
    bus.insert_accept_i = 0;
    bus.insert_data_i   = '0;
    bus.id_done_i       = 0;
    bus.id_is_dummy_i   = 0;
    bus.id_instr_i      = '0;
    bus.flush_i         = 0;
    bus.cnt_clr_i       = 0;
  endtask
  task automatic do_reset(string tag);
    idle();
    @(posedge clk);
    #2;
    rst_ni = 0;
    #1;
    q.delete();
    m_cnt = 0;
    m_err = '0;
    m_alert = 0;
    check_regs(tag);
    @(negedge clk);
    rst_ni = 1;
  endtask
  initial begin
    logic [31:0] d, w;
    bit ins, dn, tg, fl, clr;
    idle();
    repeat (2) @(negedge clk);
    check_regs("reset");
    rst_ni = 1;
    cyc("t1.push", 1, 32'h0020_8033, 0, 0, '0);
    cyc("t1.pop", 0, '0, 1, 1, 32'h0020_8033);
    chk("t1.cnt1", 32'(bus.retired_cnt_o), 32'd1);
    chk("t1.err0", 32'(bus.err_o), 32'd0);
    do_reset("rst1");
    cyc("t2.push", 1, 32'h0231_1033, 0, 0, '0);
    cyc("t2.pop", 0, '0, 1, 1, 32'h0231_1073);
    chk("t2.err", 32'(bus.err_o), 32'hC);
    chk("t2.alert_on", 32'(bus.alert_o), 32'd1);
    cyc("t2.idle", 0, '0, 0, 0, '0);
    chk("t2.alert_off", 32'(bus.alert_o), 32'd0);
    chk("t2.cnt0", 32'(bus.retired_cnt_o), 32'd0);
    do_reset("rst2");
    cyc("t3.push0", 1, 32'h0020_8033, 0, 0, '0);
    cyc("t3.push1", 1, 32'h0231_0033, 0, 0, '0);
    cyc("t3.push2", 1, 32'h0020_F033, 0, 0, '0);
    chk("t3.ovf", 32'(bus.err_o), 32'h2);
    cyc("t3.pop0", 0, '0, 1, 1, 32'h0020_8033);
    cyc("t3.pop1", 0, '0, 1, 1, 32'h0231_0033);
    chk("t3.cnt2", 32'(bus.retired_cnt_o), 32'd2);
    do_reset("rst3");
    cyc("t4.unf", 1, 32'h0020_F033, 1, 1, 32'h0020_F033);
    chk("t4.err", 32'(bus.err_o), 32'h1);
    cyc("t4.notag", 0, '0, 1, 0, 32'h0020_8033);
    cyc("t4.pop", 0, '0, 1, 1, 32'h0020_F033);
    do_reset("rst4");
    cyc("t5.push0", 1, 32'h0020_8033, 0, 0, '0);
    cyc("t5.push1", 1, 32'h0020_8033, 0, 0, '0);
    cyc("t5.flush", 1, 32'h0020_8033, 1, 1, 32'hFFFF_FFFF, 1);
    chk("t5.empty", 32'(bus.inflight_empty_o), 32'd1);
    do_reset("rst5");
    cyc("t6.fill", 1, 32'h0020_8033, 0, 0, '0);
    cyc("t6.fill2", 1, 32'h0020_8033, 0, 0, '0);
    for (int i = 0; i < 16; i++) cyc("t6.ret", 1, 32'h0020_8033, 1, 1, 32'h0020_8033);
    chk("t6.sat", 32'(bus.retired_cnt_o), 32'd15);
    cyc("t6.clr", 1, 32'h0020_8033, 1, 1, 32'h0020_8033, 0, 1);
    chk("t6.zero", 32'(bus.retired_cnt_o), 32'd0);
    do_reset("rst6");
    for (int i = 0; i < 400; i++) begin
      ins = $urandom_range(0, 1);
      d   = rand_dummy();
      dn  = $urandom_range(0, 2) == 0;
      tg  = $urandom_range(0, 3) != 0;
      fl  = $urandom_range(0, 24) == 0;
      clr = $urandom_range(0, 29) == 0;
      w   = q.size() != 0 ? q[0] : rand_dummy();
      if ($urandom_range(0, 9) == 0) w = w ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) w = $urandom;
      cyc("rnd", ins, d, dn, tg, w, fl, clr);
      if (i == 200) do_reset("rnd.rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
